mux_cfg_mem_loader: RTL

MUX_CFG_MEM_LOADER -- requirements
Module: mux_cfg_mem_loader

---
 rtl/mux_cfg_mem_loader.sv | 109 ++++++++++
 1 files changed

// File: rtl/mux_cfg_mem_loader.sv
// Serial configuration loader for one routing mux: shifts MEM_SIZE bits into a shadow
// chain and commits them atomically to the mux select lines (mem / mem_inv).
module mux_cfg_mem_loader #(
  parameter int unsigned MEM_SIZE = 8
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic                ccff_head,
  input  logic                ccff_head_valid,
  output logic                ccff_head_ready,
  output logic                ccff_tail,
  output logic [MEM_SIZE-1:0] mem,
  output logic [MEM_SIZE-1:0] mem_inv,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int unsigned CNT_W = $clog2(MEM_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_SIZE - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MEM_SIZE-1:0] shadow_q, shadow_d, shadow_shifted;
  logic [MEM_SIZE-1:0] mem_q, mem_d;
  logic                tail_q, tail_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // First bit sent ends up in the MSB once the frame is complete.
  if (MEM_SIZE > 1) begin : g_shift_wide
    assign shadow_shifted = {shadow_q[MEM_SIZE-2:0], ccff_head};
  end else begin : g_shift_one
    assign shadow_shifted = ccff_head;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tail_d   = tail_q;
    mem_d    = mem_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      SHIFT: begin
        // Abort wins over a simultaneous bit, which is dropped.
        if (cfg_abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (ccff_head_valid) begin
          shadow_d = shadow_shifted;
          tail_d   = shadow_q[MEM_SIZE-1];
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        mem_d   = shadow_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      mem_q    <= '0;
      tail_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mem_q    <= mem_d;
      tail_q   <= tail_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Derived from mem_q so sel/selb can never both be active, even in reset.
  assign mem             = mem_q;
  assign mem_inv         = ~mem_q;
  assign ccff_head_ready = (state_q == SHIFT);
  assign ccff_tail       = tail_q;
  assign cfg_done        = done_q;
  assign cfg_err         = err_q;

endmodule
